// File: rtl/magic_cfg_readback_pkg.sv
// Shared decode constants and register map for the magic config readback port.
// Optional ID register (indices 0x0E/0x0F) is enabled by defining MAGIC_RD_ID_EN.
package magic_cfg_readback_pkg;

   localparam logic [7:0] MAGIC_PORT_LO = 8'hFF;

   typedef enum logic [7:0] {
      REG_REBOOT   = 8'h00,
      REG_BEEPER   = 8'h01,
      REG_TIMINGS  = 8'h02,
      REG_TURBO    = 8'h03,
      REG_MIX      = 8'h04,
      REG_PLUS3    = 8'h05,
      REG_ALT48    = 8'h06,
      REG_JOY      = 8'h07,
      REG_RAMMODE  = 8'h08,
      REG_DIVMMC   = 8'h09,
      REG_STATUS   = 8'h0A,
      REG_FRAMECNT = 8'h0B,
      REG_ID_RST   = 8'h0E,
      REG_ID       = 8'h0F
   } magic_reg_t;

   // Element [0] is returned first after a pointer reset: "SXXS".
   localparam logic [3:0][7:0] MAGIC_ID = {8'h53, 8'h58, 8'h58, 8'h53};

   function automatic logic reg_defined(input logic [7:0] idx);
      logic ok;
      ok = (idx <= REG_FRAMECNT);
`ifdef MAGIC_RD_ID_EN
      ok = ok || (idx == REG_ID_RST) || (idx == REG_ID);
`endif
      return ok;
   endfunction

endpackage

// File: rtl/magic_cfg_readback_sticky_edge.sv
// Edge detector feeding a sticky flag; a set event on the clear clock wins.
// EDGE_RISE=1 catches 0->1, EDGE_RISE=0 catches 1->0; prev register resets to the idle level.
module sticky_edge #(
   parameter bit EDGE_RISE = 1'b1
) (
   input  logic clk28,
   input  logic rst,
   input  logic in_i,
   input  logic clr_i,
   output logic flag_o
);

   logic prev_q;
   logic flag_q;
   logic evt;

   always_comb begin
      evt = EDGE_RISE ? (in_i & ~prev_q) : (~in_i & prev_q);
   end

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         prev_q <= ~EDGE_RISE;
         flag_q <= 1'b0;
      end else begin
         prev_q <= in_i;
         flag_q <= evt | (flag_q & ~clr_i);
      end
   end

   assign flag_o = flag_q;

endmodule

// File: rtl/magic_cfg_readback.sv
// I/O read responder for port 0xNNFF while the magic ROM is mapped; data valid one clk28 after hit.
// Read byte is frozen until ioreq falls; MAGIC_RD_ID_EN adds the cycling ID register.
module magic_cfg_readback
   import magic_cfg_readback_pkg::*;
#(
   parameter int FRAME_CNT_W = 8
) (
   input  logic        clk28,
   input  logic        rst,
   input  logic [15:0] a_reg_i,
   input  logic        ioreq_i,
   input  logic        rd_i,
   input  logic        m1_i,
   input  logic        magic_map_i,
   input  logic        magic_mode_i,
   input  logic        magic_button_i,
   input  logic        n_nmi_i,
   input  logic        n_int_i,
   input  logic        magic_reboot_i,
   input  logic        magic_beeper_i,
   input  logic        rom_plus3_i,
   input  logic        rom_alt48_i,
   input  logic        joy_sinclair_i,
   input  logic        divmmc_en_i,
   input  logic        mix_acb_i,
   input  logic        mix_mono_i,
   input  logic [1:0]  timings_i,
   input  logic [1:0]  turbo_i,
   input  logic [1:0]  ram_mode_i,
   output logic [7:0]  d_out_o,
   output logic        d_out_active_o
);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t                 state_q;
   logic [7:0]             d_out_q;
   logic                   active_q;
   logic [7:0]             idx_q;
   logic                   n_int_prev_q;
   logic [FRAME_CNT_W-1:0] fcnt_q;
   logic [FRAME_CNT_W-1:0] fcnt_d;
   logic                   hit;
   logic                   acc_end;
   logic                   clr_status;
   logic                   btn_seen;
   logic                   nmi_seen;
   logic [7:0]             rd_dat;
`ifdef MAGIC_RD_ID_EN
   logic [1:0]             id_ptr_q;
`endif

   always_comb begin
      hit = magic_map_i & ioreq_i & rd_i & ~m1_i &
            (a_reg_i[7:0] == MAGIC_PORT_LO) & reg_defined(a_reg_i[15:8]);
      acc_end    = (state_q == S_ACTIVE) & ~ioreq_i;
      clr_status = acc_end & (idx_q == REG_STATUS);
   end

   sticky_edge #(.EDGE_RISE(1'b1)) u_btn (
      .clk28(clk28), .rst(rst), .in_i(magic_button_i), .clr_i(clr_status), .flag_o(btn_seen)
   );

   sticky_edge #(.EDGE_RISE(1'b0)) u_nmi (
      .clk28(clk28), .rst(rst), .in_i(n_nmi_i), .clr_i(clr_status), .flag_o(nmi_seen)
   );

   always_comb begin
      fcnt_d = fcnt_q;
      if (n_int_prev_q && !n_int_i) fcnt_d = fcnt_q + FRAME_CNT_W'(1);
   end

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         n_int_prev_q <= 1'b1;
         fcnt_q       <= '0;
      end else begin
         n_int_prev_q <= n_int_i;
         fcnt_q       <= fcnt_d;
      end
   end

   always_comb begin
      rd_dat = 8'h00;
      case (a_reg_i[15:8])
         REG_REBOOT:   rd_dat = {7'b0, magic_reboot_i};
         REG_BEEPER:   rd_dat = {7'b0, magic_beeper_i};
         REG_TIMINGS:  rd_dat = {6'b0, timings_i};
         REG_TURBO:    rd_dat = {6'b0, turbo_i};
         REG_MIX:      rd_dat = {6'b0, mix_mono_i, mix_acb_i};
         REG_PLUS3:    rd_dat = {7'b0, rom_plus3_i};
         REG_ALT48:    rd_dat = {7'b0, rom_alt48_i};
         REG_JOY:      rd_dat = {7'b0, joy_sinclair_i};
         REG_RAMMODE:  rd_dat = {6'b0, ram_mode_i};
         REG_DIVMMC:   rd_dat = {7'b0, divmmc_en_i};
         REG_STATUS:   rd_dat = {magic_mode_i, magic_button_i, 4'b0, nmi_seen, btn_seen};
         REG_FRAMECNT: rd_dat = 8'(fcnt_q);
`ifdef MAGIC_RD_ID_EN
         REG_ID:       rd_dat = MAGIC_ID[id_ptr_q];
`endif
         default:      rd_dat = 8'h00;
      endcase
   end

   // The read byte is captured on the hit clock and held for the whole access.
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         d_out_q  <= 8'h00;
         active_q <= 1'b0;
         idx_q    <= 8'h00;
`ifdef MAGIC_RD_ID_EN
         id_ptr_q <= 2'd0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (hit) begin
                  state_q  <= S_ACTIVE;
                  d_out_q  <= rd_dat;
                  active_q <= 1'b1;
                  idx_q    <= a_reg_i[15:8];
               end
            end
            S_ACTIVE: begin
               if (!ioreq_i) begin
                  state_q  <= S_IDLE;
                  active_q <= 1'b0;
`ifdef MAGIC_RD_ID_EN
                  if (idx_q == REG_ID) id_ptr_q <= id_ptr_q + 2'd1;
                  else if (idx_q == REG_ID_RST) id_ptr_q <= 2'd0;
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign d_out_o        = d_out_q;
   assign d_out_active_o = active_q;

endmodule

// File: tb/tb_magic_cfg_readback.sv
// Bench for magic_cfg_readback: constant-vector table, corner sequences, random reads vs a reference model.
// Define MAGIC_RD_ID_EN for both bench and RTL to exercise the ID register.
module tb_magic_cfg_readback;

   localparam int FCW = 8;

   logic        clk28 = 1'b0;
   logic        rst;
   logic [15:0] a_reg;
   logic        ioreq, rd, m1;
   logic        magic_map, magic_mode, magic_button, n_nmi, n_int;
   logic        magic_reboot, magic_beeper, rom_plus3, rom_alt48, joy_sinclair, divmmc_en, mix_acb, mix_mono;
   logic [1:0]  timings, turbo, ram_mode;
   logic [7:0]  d_out;
   logic        d_out_active;

   always #18 clk28 = ~clk28;

   magic_cfg_readback #(.FRAME_CNT_W(FCW)) dut (
      .clk28(clk28), .rst(rst), .a_reg_i(a_reg), .ioreq_i(ioreq), .rd_i(rd), .m1_i(m1),
      .magic_map_i(magic_map), .magic_mode_i(magic_mode), .magic_button_i(magic_button),
      .n_nmi_i(n_nmi), .n_int_i(n_int), .magic_reboot_i(magic_reboot), .magic_beeper_i(magic_beeper),
      .rom_plus3_i(rom_plus3), .rom_alt48_i(rom_alt48), .joy_sinclair_i(joy_sinclair),
      .divmmc_en_i(divmmc_en), .mix_acb_i(mix_acb), .mix_mono_i(mix_mono),
      .timings_i(timings), .turbo_i(turbo), .ram_mode_i(ram_mode),
      .d_out_o(d_out), .d_out_active_o(d_out_active)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Reference model: sticky flags, frame count, ID pointer, and whether an access is open.
   bit         m_prev_btn, m_prev_nmi, m_prev_int;
   bit         m_btn_f, m_nmi_f, m_in_acc;
   int         m_fcnt, m_ptr;
   logic [7:0] m_acc_idx;
   logic [7:0] id_str [4] = '{8'h53, 8'h58, 8'h58, 8'h53};

   function automatic void model_reset();
      m_prev_btn = 0; m_prev_nmi = 1; m_prev_int = 1;
      m_btn_f = 0; m_nmi_f = 0; m_in_acc = 0;
      m_fcnt = 0; m_ptr = 0; m_acc_idx = 8'h00;
   endfunction

   function automatic bit idx_defined(input logic [7:0] i);
      bit d;
      d = (i < 8'h0C);
`ifdef MAGIC_RD_ID_EN
      d = d || (i == 8'h0E) || (i == 8'h0F);
`endif
      return d;
   endfunction

   function automatic bit bench_hit();
      return !m_in_acc && magic_map && ioreq && rd && !m1 &&
             (a_reg[7:0] == 8'hFF) && idx_defined(a_reg[15:8]);
   endfunction

   function automatic logic [7:0] exp_byte(input logic [7:0] i);
      logic [7:0] e;
      case (i)
         8'h00: e = {7'b0, magic_reboot};
         8'h01: e = {7'b0, magic_beeper};
         8'h02: e = {6'b0, timings};
         8'h03: e = {6'b0, turbo};
         8'h04: e = {6'b0, mix_mono, mix_acb};
         8'h05: e = {7'b0, rom_plus3};
         8'h06: e = {7'b0, rom_alt48};
         8'h07: e = {7'b0, joy_sinclair};
         8'h08: e = {6'b0, ram_mode};
         8'h09: e = {7'b0, divmmc_en};
         8'h0A: e = {magic_mode, magic_button, 4'b0, m_nmi_f, m_btn_f};
         8'h0B: e = 8'(m_fcnt);
         8'h0F: e = id_str[m_ptr];
         default: e = 8'h00;
      endcase
      return e;
   endfunction

   // One clock: sample what the edge sees, advance, then update the model.
   task automatic step();
      bit s_btn, s_nmi, s_int, s_io, s_hit, clr;
      logic [7:0] s_idx;
      s_btn = magic_button; s_nmi = n_nmi; s_int = n_int; s_io = ioreq;
      s_hit = bench_hit(); s_idx = a_reg[15:8];
      @(posedge clk28);
      #1;
      clr = 0;
      if (m_in_acc && !s_io) begin
         if (m_acc_idx == 8'h0A) clr = 1;
         if (m_acc_idx == 8'h0F) m_ptr = (m_ptr + 1) % 4;
         if (m_acc_idx == 8'h0E) m_ptr = 0;
         m_in_acc = 0;
      end else if (s_hit) begin
         m_in_acc = 1;
         m_acc_idx = s_idx;
      end
      m_btn_f = (s_btn && !m_prev_btn) || (m_btn_f && !clr);
      m_nmi_f = (!s_nmi && m_prev_nmi) || (m_nmi_f && !clr);
      if (!s_int && m_prev_int) m_fcnt = (m_fcnt + 1) % (1 << FCW);
      m_prev_btn = s_btn; m_prev_nmi = s_nmi; m_prev_int = s_int;
   endtask

   task automatic read_const(input logic [15:0] addr, input bit map, input bit m1v,
                             input bit ea, input logic [7:0] ed, input string name);
      a_reg = addr; magic_map = map; m1 = m1v; ioreq = 1; rd = 1;
      step();
      check({name, "_act"}, d_out_active, ea);
      if (ea) check({name, "_dat"}, d_out, ed);
      step();
      check({name, "_hold"}, d_out_active, ea);
      if (ea) check({name, "_hdat"}, d_out, ed);
      ioreq = 0; rd = 0;
      step();
      check({name, "_end"}, d_out_active, 1'b0);
      m1 = 0;
   endtask

   task automatic rnd_async();
      if ($urandom_range(0, 3) == 0) magic_button = ~magic_button;
      if ($urandom_range(0, 3) == 0) n_nmi = ~n_nmi;
      if ($urandom_range(0, 3) == 0) n_int = ~n_int;
      if ($urandom_range(0, 7) == 0) magic_mode = ~magic_mode;
   endtask

   task automatic rnd_cfg();
      {magic_reboot, magic_beeper, rom_plus3, rom_alt48, joy_sinclair, divmmc_en, mix_acb, mix_mono} = 8'($urandom);
      timings = 2'($urandom); turbo = 2'($urandom); ram_mode = 2'($urandom);
   endtask

   task automatic rnd_read();
      logic [15:0] addr;
      bit eh;
      logic [7:0] ed;
      addr[15:8] = 8'($urandom_range(0, 17));
      addr[7:0]  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
      magic_map = ($urandom_range(0, 9) != 0);
      m1 = ($urandom_range(0, 9) == 0);
      a_reg = addr; ioreq = 1; rd = 1;
      rnd_async();
      eh = bench_hit();
      ed = exp_byte(addr[15:8]);
      step();
      check("rnd_act", d_out_active, eh);
      if (eh) check("rnd_dat", d_out, ed);
      repeat ($urandom_range(0, 2)) begin
         rnd_cfg(); rnd_async();
         step();
         check("rnd_hold_act", d_out_active, eh);
         if (eh) check("rnd_hold_dat", d_out, ed);
      end
      ioreq = 0; rd = 0; m1 = 0;
      rnd_async();
      step();
      check("rnd_end", d_out_active, 1'b0);
      repeat ($urandom_range(0, 2)) begin
         rnd_async();
         step();
      end
   endtask

   typedef struct {
      logic [15:0] addr;
      bit          map;
      bit          m1;
      logic [1:0]  tim, tur, ram;
      logic [7:0]  cfg1;
      bit          ea;
      logic [7:0]  ed;
      string       name;
   } vec_t;

   function automatic vec_t mk(input logic [15:0] addr, input bit map, input bit m1v,
                               input bit ea, input logic [7:0] ed, input string name);
      vec_t v;
      v.addr = addr; v.map = map; v.m1 = m1v;
      v.tim = 2'b01; v.tur = 2'b11; v.ram = 2'b10; v.cfg1 = 8'hA5;
      v.ea = ea; v.ed = ed; v.name = name;
      return v;
   endfunction

   initial begin
      vec_t vecs[$];
      // cfg1 = {reboot,beeper,plus3,alt48,joy,divmmc,acb,mono} = 1010_0101
      vecs.push_back(mk(16'h08FF, 1, 0, 1, 8'h02, "rd_ram"));
      vecs.push_back(mk(16'h02FF, 1, 0, 1, 8'h01, "rd_tim"));
      vecs.push_back(mk(16'h03FF, 1, 0, 1, 8'h03, "rd_turbo"));
      vecs.push_back(mk(16'h04FF, 1, 0, 1, 8'h02, "rd_mix"));
      vecs.push_back(mk(16'h00FF, 1, 0, 1, 8'h01, "rd_reboot"));
      vecs.push_back(mk(16'h01FF, 1, 0, 1, 8'h00, "rd_beep"));
      vecs.push_back(mk(16'h05FF, 1, 0, 1, 8'h01, "rd_plus3"));
      vecs.push_back(mk(16'h06FF, 1, 0, 1, 8'h00, "rd_alt48"));
      vecs.push_back(mk(16'h07FF, 1, 0, 1, 8'h00, "rd_joy"));
      vecs.push_back(mk(16'h09FF, 1, 0, 1, 8'h01, "rd_dmmc"));
      vecs.push_back(mk(16'h0AFF, 1, 0, 1, 8'h00, "rd_stat"));
      vecs.push_back(mk(16'h0BFF, 1, 0, 1, 8'h00, "rd_fcnt"));
      vecs.push_back(mk(16'h00FF, 0, 0, 0, 8'h00, "gate_map"));
      vecs.push_back(mk(16'h20FF, 1, 0, 0, 8'h00, "gate_idx"));
      vecs.push_back(mk(16'h00FF, 1, 1, 0, 8'h00, "gate_m1"));
      vecs.push_back(mk(16'h00FE, 1, 0, 0, 8'h00, "gate_lo"));
      vecs.push_back(mk(16'h0CFF, 1, 0, 0, 8'h00, "gate_0c"));
`ifdef MAGIC_RD_ID_EN
      vecs.push_back(mk(16'h0EFF, 1, 0, 1, 8'h00, "rd_idrst"));
`else
      vecs.push_back(mk(16'h0EFF, 1, 0, 0, 8'h00, "gate_0e"));
      vecs.push_back(mk(16'h0FFF, 1, 0, 0, 8'h00, "gate_0f"));
`endif

      rst = 1; a_reg = 16'h0000; ioreq = 0; rd = 0; m1 = 0;
      magic_map = 0; magic_mode = 0; magic_button = 0; n_nmi = 1; n_int = 1;
      {magic_reboot, magic_beeper, rom_plus3, rom_alt48, joy_sinclair, divmmc_en, mix_acb, mix_mono} = 8'h00;
      timings = 0; turbo = 0; ram_mode = 0;
      repeat (2) @(posedge clk28);
      #1;
      check("reset_dout", d_out, 8'h00);
      check("reset_act", d_out_active, 1'b0);
      #5 rst = 0;
      model_reset();

      foreach (vecs[i]) begin
         timings = vecs[i].tim; turbo = vecs[i].tur; ram_mode = vecs[i].ram;
         {magic_reboot, magic_beeper, rom_plus3, rom_alt48, joy_sinclair, divmmc_en, mix_acb, mix_mono} = vecs[i].cfg1;
         read_const(vecs[i].addr, vecs[i].map, vecs[i].m1, vecs[i].ea, vecs[i].ed, vecs[i].name);
      end

      // Snapshot must survive config and map changes mid-access.
      turbo = 2'b11; a_reg = 16'h03FF; magic_map = 1; ioreq = 1; rd = 1;
      step();
      check("snap_act", d_out_active, 1'b1);
      check("snap_dat", d_out, 8'h03);
      turbo = 2'b00; magic_map = 0;
      step();
      check("snap_hold1", d_out, 8'h03);
      check("snap_hold_act", d_out_active, 1'b1);
      step();
      check("snap_hold2", d_out, 8'h03);
      ioreq = 0; rd = 0; magic_map = 1;
      step();
      check("snap_end", d_out_active, 1'b0);

      magic_button = 1; step(); magic_button = 0; step();
      read_const(16'h0AFF, 1, 0, 1, 8'h01, "sticky_set");
      read_const(16'h0AFF, 1, 0, 1, 8'h00, "sticky_clr");
      a_reg = 16'h0AFF; ioreq = 1; rd = 1;
      step();
      check("sticky_co_dat", d_out, 8'h00);
      ioreq = 0; rd = 0; magic_button = 1;
      step();
      check("sticky_co_end", d_out_active, 1'b0);
      read_const(16'h0AFF, 1, 0, 1, 8'h41, "sticky_win");
      magic_button = 0; step();
      read_const(16'h0AFF, 1, 0, 1, 8'h00, "sticky_clr2");
      n_nmi = 0; step(); n_nmi = 1; magic_mode = 1; step();
      read_const(16'h0AFF, 1, 0, 1, 8'h82, "nmi_set");
      read_const(16'h0AFF, 1, 0, 1, 8'h80, "nmi_clr");
      magic_mode = 0;

      rst = 1; @(posedge clk28); #5 rst = 0; model_reset();
      repeat (255) begin n_int = 0; step(); n_int = 1; step(); end
      read_const(16'h0BFF, 1, 0, 1, 8'hFF, "fcnt_255");
      repeat (2) begin n_int = 0; step(); n_int = 1; step(); end
      read_const(16'h0BFF, 1, 0, 1, 8'h01, "fcnt_wrap");

      magic_button = 1; step(); magic_button = 0; step();
      a_reg = 16'h0AFF; ioreq = 1; rd = 1;
      step();
      check("rstmid_act", d_out_active, 1'b1);
      check("rstmid_pre", d_out, 8'h01);
      #5 rst = 1;
      #1;
      check("rstmid_dout", d_out, 8'h00);
      check("rstmid_act0", d_out_active, 1'b0);
      ioreq = 0; rd = 0;
      #3 rst = 0;
      model_reset();
      step();
      read_const(16'h0AFF, 1, 0, 1, 8'h00, "rstmid_flags");

      repeat (300) rnd_read();

`ifdef MAGIC_RD_ID_EN
      rst = 1; @(posedge clk28); #5 rst = 0; model_reset();
      magic_button = 0; n_nmi = 1; n_int = 1;
      step();
      read_const(16'h0FFF, 1, 0, 1, 8'h53, "id0");
      read_const(16'h0FFF, 1, 0, 1, 8'h58, "id1");
      read_const(16'h0FFF, 1, 0, 1, 8'h58, "id2");
      read_const(16'h0FFF, 1, 0, 1, 8'h53, "id3");
      read_const(16'h0FFF, 1, 0, 1, 8'h53, "id4");
      read_const(16'h0EFF, 1, 0, 1, 8'h00, "id_rst");
      read_const(16'h0FFF, 1, 0, 1, 8'h53, "id_after_rst");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "simulation time limit reached");
   end

endmodule
